// File: rtl/pulse_gate_counter.sv
// Gated edge counter: trigger -> programmable delay -> counting gate -> one AXI-Stream result word per gate.
// Optional macro PGC_DEADTIME_EN ignores edges for DEADTIME cycles after each counted edge.
module pulse_gate_counter #(
  parameter int COUNT_WIDTH = 16,
  parameter int GATE_WIDTH  = 32,
  parameter int DEADTIME    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  edge_in,
  input  logic                  trigger,
  input  logic [GATE_WIDTH-1:0] gate_delay,
  input  logic [GATE_WIDTH-1:0] gate_len,
  output logic [31:0]           M_AXIS_OUT_tdata,
  output logic                  M_AXIS_OUT_tvalid,
  input  logic                  M_AXIS_OUT_tready,
  output logic                  busy,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    GATE  = 2'd2
  } state_t;

  localparam logic [GATE_WIDTH-1:0] ONE = GATE_WIDTH'(1);

  state_t                  state_p0;
  logic [GATE_WIDTH-1:0]   timer_p0;
  logic [GATE_WIDTH-1:0]   len_p0;
  logic [COUNT_WIDTH-1:0]  cnt_p0;
  logic [15:0]             shot_p1;
  logic [31:0]             data_p1;
  logic                    vld_p1;
  logic                    ovf_p1;
  logic                    busy_p0;

  logic                    start;
  logic                    gate_open;
  logic                    last_cycle;
  logic                    dead_ok;
  logic                    hit;
  logic                    accept;
  logic [COUNT_WIDTH-1:0]  cnt_next;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  function automatic logic [15:0] count_field(input logic [COUNT_WIDTH-1:0] v);
    return 16'(v);
  endfunction

  assign start      = (state_p0 == IDLE) && trigger && (gate_len != '0);
  assign gate_open  = (start && (gate_delay == '0)) ||
                      ((state_p0 == DELAY) && (timer_p0 == ONE));
  assign last_cycle = (state_p0 == GATE) && (timer_p0 == ONE);
  assign hit        = (state_p0 == GATE) && edge_in && dead_ok;
  assign cnt_next   = hit ? sat_inc(cnt_p0) : cnt_p0;
  // A held word may only be replaced when it is being transferred in the same cycle.
  assign accept     = !vld_p1 || M_AXIS_OUT_tready;

`ifdef PGC_DEADTIME_EN
  localparam int DT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  logic [DT_W-1:0] dead_p0;

  assign dead_ok = (dead_p0 == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dead_p0 <= '0;
    end else if (gate_open) begin
      dead_p0 <= '0;
    end else if (state_p0 == GATE) begin
      if (hit) begin
        dead_p0 <= DT_W'(DEADTIME);
      end else if (dead_p0 != '0) begin
        dead_p0 <= dead_p0 - DT_W'(1);
      end
    end
  end
`else
  assign dead_ok = 1'b1;
`endif

  // Stage 0: gate sequencing and edge accumulation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= IDLE;
      timer_p0 <= '0;
      len_p0   <= '0;
      cnt_p0   <= '0;
      busy_p0  <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (start) begin
            len_p0  <= gate_len;
            busy_p0 <= 1'b1;
            if (gate_delay != '0) begin
              state_p0 <= DELAY;
              timer_p0 <= gate_delay;
            end else begin
              state_p0 <= GATE;
              timer_p0 <= gate_len;
              cnt_p0   <= '0;
            end
          end
        end
        DELAY: begin
          if (timer_p0 == ONE) begin
            state_p0 <= GATE;
            timer_p0 <= len_p0;
            cnt_p0   <= '0;
          end else begin
            timer_p0 <= timer_p0 - ONE;
          end
        end
        GATE: begin
          cnt_p0 <= cnt_next;
          if (last_cycle) begin
            state_p0 <= IDLE;
            busy_p0  <= 1'b0;
          end else begin
            timer_p0 <= timer_p0 - ONE;
          end
        end
        default: begin
          state_p0 <= IDLE;
          busy_p0  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: result word, stream handshake and overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shot_p1 <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ovf_p1  <= 1'b0;
    end else begin
      if (last_cycle) begin
        shot_p1 <= shot_p1 + 16'd1;
        if (accept) begin
          data_p1 <= {shot_p1, count_field(cnt_next)};
          vld_p1  <= 1'b1;
        end else begin
          ovf_p1  <= 1'b1;
        end
      end else if (vld_p1 && M_AXIS_OUT_tready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign M_AXIS_OUT_tdata  = data_p1;
  assign M_AXIS_OUT_tvalid = vld_p1;
  assign busy              = busy_p0;
  assign overflow          = ovf_p1;

endmodule

// File: tb/tb_pulse_gate_counter.sv
// Self-checking bench: directed and randomized gates against a transaction-level reference model,
// run on a 16-bit and a 4-bit count instance sharing the same stimulus.
module tb_pulse_gate_counter;
  localparam int GW = 32;
  localparam int DT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          edge_in = 1'b0;
  logic          trigger = 1'b0;
  logic          tready = 1'b0;
  logic [GW-1:0] gate_delay = '0;
  logic [GW-1:0] gate_len = '0;
  logic [31:0]   tdata, tdata4;
  logic          tvalid, tvalid4, busy, busy4, ovf, ovf4;

  always #4 clk = ~clk;

  pulse_gate_counter #(.COUNT_WIDTH(16), .GATE_WIDTH(GW), .DEADTIME(DT)) dut (
    .clk(clk), .rst(rst), .edge_in(edge_in), .trigger(trigger),
    .gate_delay(gate_delay), .gate_len(gate_len),
    .M_AXIS_OUT_tdata(tdata), .M_AXIS_OUT_tvalid(tvalid), .M_AXIS_OUT_tready(tready),
    .busy(busy), .overflow(ovf)
  );

  pulse_gate_counter #(.COUNT_WIDTH(4), .GATE_WIDTH(GW), .DEADTIME(DT)) dut4 (
    .clk(clk), .rst(rst), .edge_in(edge_in), .trigger(trigger),
    .gate_delay(gate_delay), .gate_len(gate_len),
    .M_AXIS_OUT_tdata(tdata4), .M_AXIS_OUT_tvalid(tvalid4), .M_AXIS_OUT_tready(tready),
    .busy(busy4), .overflow(ovf4)
  );

  int          checks = 0;
  int          passes = 0;
  bit          exp_valid = 1'b0;
  bit          exp_ovf = 1'b0;
  bit          exp_busy = 1'b0;
  logic [31:0] exp_word = '0;
  logic [31:0] exp_word4 = '0;
  int          shot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s @%0t: observed 0x%08h expected 0x%08h", tag, $time, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tvalid"},  {31'b0, tvalid},  {31'b0, exp_valid});
    chk({tag, ".tvalid4"}, {31'b0, tvalid4}, {31'b0, exp_valid});
    if (exp_valid) begin
      chk({tag, ".tdata"},  tdata,  exp_word);
      chk({tag, ".tdata4"}, tdata4, exp_word4);
    end
    chk({tag, ".ovf"},   {31'b0, ovf},   {31'b0, exp_ovf});
    chk({tag, ".ovf4"},  {31'b0, ovf4},  {31'b0, exp_ovf});
    chk({tag, ".busy"},  {31'b0, busy},  {31'b0, exp_busy});
    chk({tag, ".busy4"}, {31'b0, busy4}, {31'b0, exp_busy});
  endtask

  // One clock edge; the model applies the stream rules using the tready value seen at that edge.
  task automatic tick(input bit result, input int n);
    @(posedge clk);
    if (result) begin
      if (exp_valid && !tready) begin
        exp_ovf = 1'b1;
      end else begin
        exp_valid = 1'b1;
        exp_word  = {shot[15:0], (n > 65535) ? 16'hFFFF : n[15:0]};
        exp_word4 = {shot[15:0], 12'h000, (n > 15) ? 4'hF : n[3:0]};
      end
      shot = (shot + 1) % 65536;
    end else if (exp_valid && tready) begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      trigger = 1'b0;
      edge_in = 1'($urandom % 2);
      tready  = rdy;
      tick(1'b0, 0);
      check_all("idle");
    end
  endtask

  // Launch one gate and follow it to its result, scrambling inputs that must be ignored meanwhile.
  task automatic shot_run(input int d, input int l, input bit rdy, input bit rnd,
                          input logic [63:0] mask, input string tag);
    int n;
    int last;
    bit e;
    n    = 0;
    last = -1000;
    trigger    = 1'b1;
    gate_delay = GW'(d);
    gate_len   = GW'(l);
    tready     = rdy;
    edge_in    = 1'b1;
    tick(1'b0, 0);
    exp_busy = 1'b1;
    for (int c = 1; c <= d + l; c++) begin
      check_all(tag);
      trigger    = 1'($urandom % 2);
      gate_delay = GW'($urandom_range(0, 50));
      gate_len   = GW'($urandom_range(0, 50));
      e = rnd ? 1'($urandom % 2) : mask[c-1];
      edge_in = e;
      if (c > d && e) begin
`ifdef PGC_DEADTIME_EN
        if (c - last > DT) begin
          n++;
          last = c;
        end
`else
        n++;
`endif
      end
      tick(c == d + l, n);
    end
    exp_busy = 1'b0;
    trigger  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int d;
    int l;
    bit rdy;

    #20;
    chk("reset.tdata", tdata, 32'h0);
    chk("reset.tdata4", tdata4, 32'h0);
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    trigger = 1'b1; gate_len = '0; gate_delay = GW'(3); tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 0);
      check_all("len0");
    end

    shot_run(0, 10, 1'b1, 1'b0, 64'h0000_0000_0000_0124, "d0l10");
    idle(1, 1'b1);
    shot_run(5, 4, 1'b1, 1'b0, 64'h0000_0000_0000_013B, "d5l4");
    shot_run(0, 40, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "sat");
    idle(2, 1'b1);

    for (int s = 0; s < 25; s++) begin
      d   = $urandom_range(0, 6);
      l   = $urandom_range(1, 40);
      rdy = ($urandom % 4) != 0;
      shot_run(d, l, rdy, 1'b1, 64'h0, "rand");
      idle($urandom_range(0, 2), 1'($urandom % 2));
    end

    trigger = 1'b1; gate_delay = GW'(2); gate_len = GW'(20); tready = 1'b1; edge_in = 1'b1;
    tick(1'b0, 0);
    trigger = 1'b0;
    repeat (6) tick(1'b0, 0);
    #1 rst = 1'b0;
    #1;
    exp_valid = 1'b0; exp_ovf = 1'b0; exp_busy = 1'b0; shot = 0;
    chk("midrst.tdata", tdata, 32'h0);
    chk("midrst.tdata4", tdata4, 32'h0);
    check_all("midrst");
    @(negedge clk);
    rst = 1'b1;
    idle(30, 1'b1);

    shot_run(1, 3, 1'b0, 1'b1, 64'h0, "hold_a");
    shot_run(0, 2, 1'b0, 1'b1, 64'h0, "hold_b");
    chk("hold.shot", {16'h0, tdata[31:16]}, 32'd0);
    chk("hold.ovf", {31'b0, ovf}, 32'd1);
    shot_run(0, 3, 1'b1, 1'b1, 64'h0, "hold_c");
    chk("hold.shot2", {16'h0, tdata[31:16]}, 32'd2);
    idle(2, 1'b1);

    #1 rst = 1'b0;
    #1;
    exp_valid = 1'b0; exp_ovf = 1'b0; exp_busy = 1'b0; shot = 0;
    check_all("finalrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
